// File: rtl/pipeline_ctx_ctrl.sv
// pipeline_ctx_ctrl
//   Pipeline control for the RISC-V core: per-stage enable/flush/valid
//   tracking with busywait > branch flush > load-use stall priority, plus an
//   OS context-switch sequencer that drains the pipeline, swaps the active
//   cache context and resumes fetch.
//
//   State   | meaning
//   --------+---------------------------------------------------------------
//   RUN     | normal operation, context requests accepted
//   DRAIN   | fetch held, bubbles injected until every stage is empty
//   SWITCH  | cache bank swap in progress for SWITCH_CYCLES cycles
//   RESUME  | one-cycle ctx_ack, fetch released
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   fetch_valid                IF presents a valid instruction for stage 0
//   id_rs1/id_rs2/id_rs_used   source registers of the stage-0 instruction
//   ex_load/ex_rd              stage-1 load flag and destination register
//   mem_busywait               memory busywait, freezes the pipeline
//   branch_taken               taken branch resolved in stage 1
//   ctx_req/ctx_id             context-switch request and target context
//   stage_en/stage_flush       per-stage register enable / synchronous clear
//   stage_valid                registered valid bit per stage
//   pc_hold                    suppress sequential PC increment
//   load_use_stall             load-use stall active this cycle
//   cache_switch               cache bank swap in progress
//   cache_ctx                  active cache context
//   ctx_ack                    one-cycle completion pulse
//   perf_stall_cnt             stall-cycle counter (0 unless perf build)
//   perf_switch_lat            last switch latency (0 unless perf build)
//
// Build option:
//   CTX_SWITCH_PERF_EN  when defined, the two perf outputs carry saturating
//                       counters; otherwise they are tied to zero.

module pipeline_ctx_ctrl #(
  parameter int NUM_STAGES    = 4,
  parameter int REG_AW        = 5,
  parameter int CTX_W         = 2,
  parameter int SWITCH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic [1:0]            id_rs_used,
  input  logic                  ex_load,
  input  logic [REG_AW-1:0]     ex_rd,
  input  logic                  mem_busywait,
  input  logic                  branch_taken,
  input  logic                  ctx_req,
  input  logic [CTX_W-1:0]      ctx_id,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  pc_hold,
  output logic                  load_use_stall,
  output logic                  cache_switch,
  output logic [CTX_W-1:0]      cache_ctx,
  output logic                  ctx_ack,
  output logic [15:0]           perf_stall_cnt,
  output logic [15:0]           perf_switch_lat
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  localparam logic [7:0] SW_LAST = 8'(SWITCH_CYCLES - 1);

  state_t                  state_q;
  logic [7:0]              sw_cnt_q;
  logic [CTX_W-1:0]        pend_ctx_q;
  logic [CTX_W-1:0]        cache_ctx_q;
  logic                    cache_switch_q;
  logic                    ctx_ack_q;
  logic [NUM_STAGES-1:0]   valid_q;

  logic                    rs1_hit;
  logic                    rs2_hit;
  logic                    hazard;
  logic                    br_flush;
  logic                    inject_bubble;
  logic                    draining;
  logic [NUM_STAGES-1:0]   en_d;
  logic [NUM_STAGES-1:0]   flush_d;
  logic                    hold_d;
  logic                    stall_d;

  assign rs1_hit  = id_rs_used[0] && (id_rs1 == ex_rd);
  assign rs2_hit  = id_rs_used[1] && (id_rs2 == ex_rd);
  assign hazard   = valid_q[0] && valid_q[1] && ex_load &&
                    (ex_rd != '0) && (rs1_hit || rs2_hit);
  assign br_flush = branch_taken && valid_q[1];

  assign draining      = (state_q == ST_DRAIN) || (state_q == ST_SWITCH);
  assign inject_bubble = draining;

  always_comb begin
    en_d    = '1;
    flush_d = '0;
    hold_d  = 1'b0;
    stall_d = 1'b0;
    if (reset) begin
      en_d    = '0;
      flush_d = '1;
    end else if (mem_busywait) begin
      en_d   = '0;
      hold_d = 1'b1;
    end else if (br_flush) begin
      flush_d[1:0] = 2'b11;
    end else if (hazard) begin
      stall_d  = 1'b1;
      en_d[0]  = 1'b0;
      flush_d[1] = 1'b1;
      hold_d   = 1'b1;
    end
    // The drain sequence keeps sequential fetch suppressed even across a
    // branch flush; the redirect itself is still taken by the fetch unit.
    if (!reset && draining) hold_d = 1'b1;
  end

  assign stage_en       = en_d;
  assign stage_flush    = flush_d;
  assign pc_hold        = hold_d;
  assign load_use_stall = stall_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (flush_d[0])   valid_q[0] <= 1'b0;
      else if (en_d[0]) valid_q[0] <= fetch_valid && !inject_bubble;
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (flush_d[i])   valid_q[i] <= 1'b0;
        else if (en_d[i]) valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign stage_valid = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      sw_cnt_q       <= 8'd0;
      pend_ctx_q     <= '0;
      cache_ctx_q    <= '0;
      cache_switch_q <= 1'b0;
      ctx_ack_q      <= 1'b0;
    end else begin
      ctx_ack_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (!mem_busywait && ctx_req) begin
            if (ctx_id == cache_ctx_q) begin
              ctx_ack_q <= 1'b1;
            end else begin
              pend_ctx_q <= ctx_id;
              state_q    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!mem_busywait && (valid_q == '0)) begin
            state_q        <= ST_SWITCH;
            sw_cnt_q       <= 8'd0;
            cache_switch_q <= 1'b1;
          end
        end
        ST_SWITCH: begin
          // The bank swap runs on its own timer, independent of busywait.
          if (sw_cnt_q == SW_LAST) begin
            cache_ctx_q    <= pend_ctx_q;
            cache_switch_q <= 1'b0;
            ctx_ack_q      <= 1'b1;
            state_q        <= ST_RESUME;
          end else begin
            sw_cnt_q <= sw_cnt_q + 8'd1;
          end
        end
        ST_RESUME: begin
          state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign cache_switch = cache_switch_q;
  assign cache_ctx    = cache_ctx_q;
  assign ctx_ack      = ctx_ack_q;

`ifdef CTX_SWITCH_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] lat_run_q;
  logic [15:0] lat_cap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      lat_run_q   <= 16'd0;
      lat_cap_q   <= 16'd0;
    end else begin
      if ((mem_busywait || stall_d) && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      // lat_run_q counts cycles since DRAIN entry; in RESUME (the ack cycle)
      // it holds the full distance and is captured.
      if (state_q == ST_RUN)
        lat_run_q <= 16'd0;
      else if (lat_run_q != 16'hFFFF)
        lat_run_q <= lat_run_q + 16'd1;
      if (state_q == ST_RESUME)
        lat_cap_q <= lat_run_q;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_switch_lat = lat_cap_q;
`else
  assign perf_stall_cnt  = 16'd0;
  assign perf_switch_lat = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctx_ctrl.sv
// Directed bench for pipeline_ctx_ctrl: load-use, branch priority,
// busywait freeze, context switch, same-context ack and reset mid-switch.

module tb_pipeline_ctx_ctrl;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [1:0]  id_rs_used;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        mem_busywait;
  logic        branch_taken;
  logic        ctx_req;
  logic [1:0]  ctx_id;
  logic [3:0]  stage_en;
  logic [3:0]  stage_flush;
  logic [3:0]  stage_valid;
  logic        pc_hold;
  logic        load_use_stall;
  logic        cache_switch;
  logic [1:0]  cache_ctx;
  logic        ctx_ack;
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_switch_lat;

  int n_tests = 0;
  int n_fail  = 0;
  int acks;
  logic [3:0] ev;

  pipeline_ctx_ctrl #(
    .NUM_STAGES(4), .REG_AW(5), .CTX_W(2), .SWITCH_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_used(id_rs_used),
    .ex_load(ex_load), .ex_rd(ex_rd), .mem_busywait(mem_busywait),
    .branch_taken(branch_taken), .ctx_req(ctx_req), .ctx_id(ctx_id),
    .stage_en(stage_en), .stage_flush(stage_flush), .stage_valid(stage_valid),
    .pc_hold(pc_hold), .load_use_stall(load_use_stall),
    .cache_switch(cache_switch), .cache_ctx(cache_ctx), .ctx_ack(ctx_ack),
    .perf_stall_cnt(perf_stall_cnt), .perf_switch_lat(perf_switch_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs_used = '0;
    ex_load = 1'b0; ex_rd = '0; mem_busywait = 1'b0; branch_taken = 1'b0;
    ctx_req = 1'b0; ctx_id = '0;

    // reset state
    step(); step();
    chk("rst_flush", 32'(stage_flush), 32'hF);
    chk("rst_en",    32'(stage_en), 32'h0);
    chk("rst_hold",  32'(pc_hold), 32'h0);
    chk("rst_valid", 32'(stage_valid), 32'h0);
    chk("rst_ctx",   32'(cache_ctx), 32'h0);
    chk("rst_sw",    32'(cache_switch), 32'h0);
    chk("rst_ack",   32'(ctx_ack), 32'h0);
`ifndef CTX_SWITCH_PERF_EN
    chk("perf_stall_tied", 32'(perf_stall_cnt), 32'h0);
    chk("perf_lat_tied",   32'(perf_switch_lat), 32'h0);
`endif

    // load-use on rs1
    reset = 1'b0; fetch_valid = 1'b1;
    step(); step();
    chk("fill2", 32'(stage_valid), 32'b0011);
    fetch_valid = 1'b0; ex_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs_used = 2'b01;
    #1;
    chk("lu_stall", 32'(load_use_stall), 32'h1);
    chk("lu_en",    32'(stage_en), 32'b1110);
    chk("lu_flush", 32'(stage_flush), 32'b0010);
    chk("lu_hold",  32'(pc_hold), 32'h1);
    id_rs1 = 5'd3; id_rs2 = 5'd5; #1;
    chk("lu_rs2_unused", 32'(load_use_stall), 32'h0);
    id_rs_used = 2'b10; #1;
    chk("lu_rs2", 32'(load_use_stall), 32'h1);
    id_rs_used = 2'b01; id_rs1 = 5'd5; id_rs2 = 5'd0; ex_load = 1'b0; #1;
    chk("lu_noload", 32'(load_use_stall), 32'h0);
    ex_load = 1'b1;
    step();
    chk("lu_valid_after", 32'(stage_valid), 32'b0101);
    chk("lu_next_stall",  32'(load_use_stall), 32'h0);
    chk("lu_next_en",     32'(stage_en), 32'hF);
    chk("lu_next_hold",   32'(pc_hold), 32'h0);

    // ex_rd = x0 never stalls
    ex_load = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; fetch_valid = 1'b1;
    step(); step();
    fetch_valid = 1'b0; ex_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs_used = 2'b01;
    #1;
    chk("lu_rd0_stall", 32'(load_use_stall), 32'h0);
    chk("lu_rd0_en",    32'(stage_en), 32'hF);

    // branch beats load-use
    ex_rd = 5'd5; id_rs1 = 5'd5; #1;
    chk("br_pre_stall", 32'(load_use_stall), 32'h1);
    branch_taken = 1'b1; #1;
    chk("br_flush", 32'(stage_flush), 32'b0011);
    chk("br_stall", 32'(load_use_stall), 32'h0);
    chk("br_hold",  32'(pc_hold), 32'h0);
    chk("br_en",    32'(stage_en), 32'hF);
    step();
    chk("br_valid", 32'(stage_valid), 32'b0100);

    // busywait freezes even with a taken branch
    branch_taken = 1'b0; ex_load = 1'b0; fetch_valid = 1'b1;
    step(); step();
    chk("bw_pre_valid", 32'(stage_valid), 32'b0011);
    mem_busywait = 1'b1; branch_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bw_en",    32'(stage_en), 32'h0);
      chk("bw_flush", 32'(stage_flush), 32'h0);
      chk("bw_hold",  32'(pc_hold), 32'h1);
      chk("bw_valid", 32'(stage_valid), 32'b0011);
      step();
    end
    mem_busywait = 1'b0; #1;
    chk("bw_rel_flush", 32'(stage_flush), 32'b0011);
    chk("bw_rel_en",    32'(stage_en), 32'hF);
    chk("bw_rel_hold",  32'(pc_hold), 32'h0);
    step();
    branch_taken = 1'b0; fetch_valid = 1'b0;
    chk("bw_rel_valid", 32'(stage_valid), 32'b0100);

    // full context switch 0 -> 2
    reset = 1'b1;
    step();
    reset = 1'b0; fetch_valid = 1'b1;
    step(); step(); step(); step();
    chk("cs_full", 32'(stage_valid), 32'hF);
    ctx_req = 1'b1; ctx_id = 2'd2; #1;
    chk("cs_req_hold", 32'(pc_hold), 32'h0);
    step();
    ctx_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      ev = 4'hF << k;
      chk("cs_drain_valid", 32'(stage_valid), 32'(ev));
      chk("cs_drain_hold",  32'(pc_hold), 32'h1);
      chk("cs_drain_sw",    32'(cache_switch), 32'h0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cs_sw",      32'(cache_switch), 32'h1);
      chk("cs_sw_hold", 32'(pc_hold), 32'h1);
      chk("cs_sw_ack",  32'(ctx_ack), 32'h0);
      chk("cs_sw_ctx",  32'(cache_ctx), 32'h0);
      step();
    end
    #1;
    chk("cs_ack",      32'(ctx_ack), 32'h1);
    chk("cs_ctx",      32'(cache_ctx), 32'h2);
    chk("cs_sw_done",  32'(cache_switch), 32'h0);
    chk("cs_res_hold", 32'(pc_hold), 32'h0);
    step();
    chk("cs_ack_clr", 32'(ctx_ack), 32'h0);

    // same-context request: immediate ack, no drain
    ctx_req = 1'b1; ctx_id = 2'd2; #1;
    chk("same_req_hold", 32'(pc_hold), 32'h0);
    step();
    ctx_req = 1'b0; #1;
    chk("same_ack",  32'(ctx_ack), 32'h1);
    chk("same_hold", 32'(pc_hold), 32'h0);
    step();
    chk("same_ack_clr",  32'(ctx_ack), 32'h0);
    chk("same_hold2",    32'(pc_hold), 32'h0);
    chk("same_ctx",      32'(cache_ctx), 32'h2);

    // reset in the second SWITCH cycle aborts without ack
    fetch_valid = 1'b0;
    step(); step(); step(); step();
    chk("rm_empty", 32'(stage_valid), 32'h0);
    ctx_req = 1'b1; ctx_id = 2'd1;
    step();
    ctx_req = 1'b0; #1;
    chk("rm_drain_hold", 32'(pc_hold), 32'h1);
    step();
    chk("rm_sw1", 32'(cache_switch), 32'h1);
    step();
    chk("rm_sw2", 32'(cache_switch), 32'h1);
    reset = 1'b1; #1;
    chk("rm_rst_flush", 32'(stage_flush), 32'hF);
    step();
    reset = 1'b0; #1;
    chk("rm_ctx",  32'(cache_ctx), 32'h0);
    chk("rm_sw",   32'(cache_switch), 32'h0);
    chk("rm_ack",  32'(ctx_ack), 32'h0);
    chk("rm_hold", 32'(pc_hold), 32'h0);
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      if (ctx_ack) acks++;
      step();
    end
    chk("rm_no_ack", 32'(acks), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
